// File: rtl/ssd1306_procedure_scheduler.sv
// Round-robin scheduler that hands SSD1306 microcode procedures to a single
// executor, running the power-up init procedure before any requester is served.
module ssd1306_procedure_scheduler #(
   parameter int MICROCODE_SIZE = 48,
   parameter int NUM_REQ        = 4,
   parameter int INIT_OFFSET    = 0,
   localparam int ADDR_W = (MICROCODE_SIZE > 1) ? $clog2(MICROCODE_SIZE) : 1,
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic [NUM_REQ-1:0]        req_in,
   input  logic [NUM_REQ*ADDR_W-1:0] req_offset_in,
   output logic [NUM_REQ-1:0]        grant_out,
   output logic [NUM_REQ-1:0]        done_out,
   output logic                      init_done_out,
   output logic                      busy_out,
   output logic [ADDR_W-1:0]         procedure_offset_out,
   output logic                      procedure_start_out,
   input  logic                      procedure_done_in
);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_IDLE  = 2'd1,
      S_START = 2'd2,
      S_BUSY  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [NUM_REQ-1:0]   r_pending;
   logic [IDX_W-1:0]     r_last;
   logic [IDX_W-1:0]     r_owner;
   logic                 r_owner_boot;
   logic [ADDR_W-1:0]    r_offset;
   logic [NUM_REQ-1:0]   r_grant;
   logic [NUM_REQ-1:0]   r_done;
   logic                 r_init_done;

   logic                 w_arb;
   logic [IDX_W-1:0]     w_winner;
   logic [IDX_W-1:0]     w_idx;
   logic [ADDR_W-1:0]    w_win_off;
   logic [NUM_REQ-1:0]   w_grant_vec;

   assign w_arb = (r_state == S_IDLE) && r_init_done && (|r_pending);

   // Scan downward so the last hit is the closest index after r_last.
   always_comb begin
      w_winner = '0;
      w_idx    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = IDX_W'((int'(r_last) + 1 + k) % NUM_REQ);
         if (r_pending[w_idx]) begin
            w_winner = w_idx;
         end
      end
   end

   assign w_win_off = req_offset_in[int'(w_winner) * ADDR_W +: ADDR_W];

   always_comb begin
      w_grant_vec = '0;
      if (w_arb) begin
         w_grant_vec[w_winner] = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_BOOT:  if (procedure_done_in)  w_next = S_START;
         S_IDLE:  if (w_arb)              w_next = S_START;
         S_START: if (!procedure_done_in) w_next = S_BUSY;
         S_BUSY:  if (procedure_done_in)  w_next = S_IDLE;
         default:                         w_next = S_BOOT;
      endcase
   end

   always_comb begin
      procedure_start_out = (r_state == S_START);
      busy_out            = (r_state != S_IDLE);
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_pending    <= '0;
         r_last       <= IDX_W'(NUM_REQ - 1);
         r_owner      <= '0;
         r_owner_boot <= 1'b1;
         r_offset     <= '0;
         r_grant      <= '0;
         r_done       <= '0;
         r_init_done  <= 1'b0;
      end else begin
         r_grant   <= '0;
         r_done    <= '0;
         // A new request on the grant cycle re-arms the requester.
         r_pending <= (r_pending & ~w_grant_vec) | req_in;
         unique case (r_state)
            S_BOOT: begin
               if (procedure_done_in) begin
                  r_offset     <= ADDR_W'(INIT_OFFSET);
                  r_owner_boot <= 1'b1;
               end
            end
            S_IDLE: begin
               if (w_arb) begin
                  r_grant      <= w_grant_vec;
                  r_offset     <= w_win_off;
                  r_last       <= w_winner;
                  r_owner      <= w_winner;
                  r_owner_boot <= 1'b0;
               end
            end
            S_BUSY: begin
               if (procedure_done_in) begin
                  if (r_owner_boot) begin
                     r_init_done <= 1'b1;
                  end else begin
                     r_done[r_owner] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign grant_out            = r_grant;
   assign done_out             = r_done;
   assign init_done_out        = r_init_done;
   assign procedure_offset_out = r_offset;

endmodule

// File: tb/tb_ssd1306_procedure_scheduler.sv
// Directed bench for ssd1306_procedure_scheduler with a small executor model
// that drops done 2 cycles after start and raises it 10 cycles later.
module tb_ssd1306_procedure_scheduler;

   localparam int NR = 4;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset_in;
   logic [NR-1:0] req_in;
   logic [NR*AW-1:0] offs;
   logic [NR-1:0] grant_out;
   logic [NR-1:0] done_out;
   logic          init_done_out;
   logic          busy_out;
   logic [AW-1:0] procedure_offset_out;
   logic          procedure_start_out;
   logic          procedure_done_in;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int viol    = 0;
   int ex_t    = 0;

   typedef struct {
      logic [NR-1:0] req;
      int n;
      int o0;
      int o1;
      int o2;
      int o3;
   } vec_t;

   vec_t tbl[7];

   ssd1306_procedure_scheduler #(
      .MICROCODE_SIZE(48),
      .NUM_REQ(NR),
      .INIT_OFFSET(0)
   ) dut (
      .clk_in(clk),
      .reset_in(reset_in),
      .req_in(req_in),
      .req_offset_in(offs),
      .grant_out(grant_out),
      .done_out(done_out),
      .init_done_out(init_done_out),
      .busy_out(busy_out),
      .procedure_offset_out(procedure_offset_out),
      .procedure_start_out(procedure_start_out),
      .procedure_done_in(procedure_done_in)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset_in) begin
         if (!init_done_out && (grant_out != 0 || done_out != 0)) viol++;
         if ($countones(grant_out) > 1 || $countones(done_out) > 1) viol++;
      end
   end

   initial begin
      procedure_done_in = 1'b1;
      forever begin
         @(negedge clk);
         if (reset_in) begin
            procedure_done_in = 1'b1;
            ex_t = 0;
         end else if (ex_t == 0) begin
            if (procedure_start_out) ex_t = 1;
         end else begin
            ex_t++;
            if (ex_t == 2) begin
               procedure_done_in = 1'b0;
            end else if (ex_t == 12) begin
               procedure_done_in = 1'b1;
               ex_t = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int off_of(input int i);
      return int'(offs[i*AW +: AW]);
   endfunction

   function automatic int ord_at(input vec_t v, input int j);
      case (j)
         0: return v.o0;
         1: return v.o1;
         2: return v.o2;
         default: return v.o3;
      endcase
   endfunction

   task automatic check_reset(input string tag);
      check({tag, " busy"}, int'(busy_out), 1);
      check({tag, " start"}, int'(procedure_start_out), 0);
      check({tag, " grant"}, int'(grant_out), 0);
      check({tag, " done"}, int'(done_out), 0);
      check({tag, " init_done"}, int'(init_done_out), 0);
      check({tag, " offset"}, int'(procedure_offset_out), 0);
   endtask

   task automatic pulse(input logic [NR-1:0] m);
      req_in = m;
      @(negedge clk);
      req_in = '0;
   endtask

   task automatic wait_grant(input int idx, input string tag);
      bit hit = 0;
      for (int k = 0; k < 40; k++) begin
         if (grant_out != 0) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      if (!hit) begin
         check({tag, " grant timeout"}, 0, 1);
      end else begin
         check({tag, " grant"}, int'(grant_out), 1 << idx);
         check({tag, " offset"}, int'(procedure_offset_out), off_of(idx));
         check({tag, " start"}, int'(procedure_start_out), 1);
      end
   endtask

   task automatic wait_done(input int idx, input string tag);
      bit hit = 0;
      for (int k = 0; k < 40; k++) begin
         if (done_out != 0) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      if (!hit) check({tag, " done timeout"}, 0, 1);
      else check({tag, " done"}, int'(done_out), 1 << idx);
   endtask

   task automatic wait_boot(input string tag);
      bit hit = 0;
      for (int k = 0; k < 10; k++) begin
         if (procedure_start_out) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      check({tag, " start seen"}, int'(hit), 1);
      check({tag, " init offset"}, int'(procedure_offset_out), 0);
      check({tag, " no grant"}, int'(grant_out), 0);
      hit = 0;
      for (int k = 0; k < 40; k++) begin
         if (init_done_out) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      check({tag, " init_done"}, int'(hit), 1);
      check({tag, " idle after init"}, int'(busy_out), 0);
   endtask

   task automatic idle_check(input string tag);
      int g = 0;
      repeat (15) begin
         @(negedge clk);
         if (grant_out != 0) g++;
      end
      check({tag, " stray grants"}, g, 0);
      check({tag, " busy"}, int'(busy_out), 0);
   endtask

   initial begin
      int ci;
      int seq_d[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
      tbl[0] = '{4'b0101, 2, 0, 2, 0, 0};
      tbl[1] = '{4'b1010, 2, 3, 1, 0, 0};
      tbl[2] = '{4'b1111, 4, 2, 3, 0, 1};
      tbl[3] = '{4'b0001, 1, 0, 0, 0, 0};
      tbl[4] = '{4'b0001, 1, 0, 0, 0, 0};
      tbl[5] = '{4'b0110, 2, 1, 2, 0, 0};
      tbl[6] = '{4'b1001, 2, 3, 0, 0, 0};

      reset_in = 1'b1;
      req_in   = '0;
      offs     = {6'd17, 6'd13, 6'd9, 6'd5};
      repeat (3) @(negedge clk);
      #1 check_reset("reset");

      @(negedge clk);
      reset_in = 1'b0;
      pulse(4'b0010);
      wait_boot("boot1");
      ci = cyc;
      wait_grant(1, "req_during_boot");
      check("req_during_boot latency", cyc - ci, 1);

      repeat (5) @(negedge clk);
      check("mid busy state", int'(busy_out), 1);
      reset_in = 1'b1;
      #1 check_reset("mid_busy_reset");
      repeat (3) @(negedge clk);
      reset_in = 1'b0;
      wait_boot("boot2");

      for (int v = 0; v < 7; v++) begin
         pulse(tbl[v].req);
         for (int j = 0; j < tbl[v].n; j++) begin
            wait_grant(ord_at(tbl[v], j), $sformatf("vec%0d.%0d", v, j));
            wait_done(ord_at(tbl[v], j), $sformatf("vec%0d.%0d", v, j));
         end
         idle_check($sformatf("vec%0d", v));
      end

      req_in = 4'b1111;
      for (int j = 0; j < 10; j++) begin
         wait_grant(seq_d[j], $sformatf("held%0d", j));
         if (j == 5) req_in = '0;
         @(negedge clk);
         check($sformatf("held%0d pulse width", j), int'(grant_out), 0);
         wait_done(seq_d[j], $sformatf("held%0d", j));
      end
      idle_check("held");

      pulse(4'b1011);
      wait_grant(3, "rearm first");
      pulse(4'b1000);
      wait_done(3, "rearm first");
      wait_grant(0, "rearm r0");
      wait_done(0, "rearm r0");
      wait_grant(1, "rearm r1");
      wait_done(1, "rearm r1");
      wait_grant(3, "rearm second");
      wait_done(3, "rearm second");
      idle_check("rearm");

      offs[2*AW +: AW] = 6'd60;
      pulse(4'b0100);
      wait_grant(2, "oversize");
      check("oversize literal offset", int'(procedure_offset_out), 60);
      wait_done(2, "oversize");

      check("monitor violations", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ssd1306_procedure_scheduler.md
SSD1306_PROCEDURE_SCHEDULER -- requirements
Module: ssd1306_procedure_scheduler

Interface
REQ-001 SHALL have parameter MICROCODE_SIZE, default 48, microcode depth; ADDR_W = clog2(MICROCODE_SIZE).
REQ-002 SHALL have parameter NUM_REQ, default 4, number of procedure requesters (2..8).
REQ-003 SHALL have parameter INIT_OFFSET, default 0, microcode offset of the power-up init procedure.
REQ-004 SHALL have port clk_in  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_in  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req_in  input  NUM_REQ  per-requester request pulse or level.
REQ-007 SHALL have port req_offset_in  input  NUM_REQ*ADDR_W  packed procedure offsets; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port grant_out  output  NUM_REQ  one-hot 1-cycle pulse when a requester's procedure is selected.
REQ-009 SHALL have port done_out  output  NUM_REQ  one-hot 1-cycle pulse when that requester's procedure completes.
REQ-010 SHALL have port init_done_out  output  1  high once the init procedure has completed.
REQ-011 SHALL have port busy_out  output  1  high when not in S_IDLE.
REQ-012 SHALL have port procedure_offset_out  output  ADDR_W  offset presented to the microcode executor.
REQ-013 SHALL have port procedure_start_out  output  1  start request to the executor.
REQ-014 SHALL have port procedure_done_in  input  1  executor idle/done level (high = idle).

Function
REQ-015 SHALL keep a pending register: pending[i] set on any cycle req_in[i]=1, cleared on the cycle grant_out[i] pulses; set wins when both coincide.
REQ-016 SHALL implement states S_BOOT, S_IDLE, S_START, S_BUSY.
REQ-017 S_BOOT: SHALL wait for procedure_done_in=1, then load procedure_offset_out=INIT_OFFSET, mark owner=boot, go S_START; no grant_out pulse for boot.
REQ-018 S_IDLE: SHALL arbitrate only when init_done_out=1 and pending nonzero; winner = first set pending index searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-019 On arbitration SHALL, in the same edge, pulse grant_out[winner], latch req_offset_in of winner into procedure_offset_out, update last_grant, go S_START.
REQ-020 S_START: SHALL hold procedure_start_out=1 and procedure_offset_out stable until procedure_done_in=0, then go S_BUSY.
REQ-021 procedure_start_out SHALL be 1 only in S_START (registered/decoded from state, no glitch).
REQ-022 S_BUSY: when procedure_done_in=1 SHALL pulse done_out[owner] (or set init_done_out if owner=boot) and go S_IDLE next cycle.
REQ-023 Arbitration-to-start latency SHALL be exactly 1 cycle (grant edge -> start high).
REQ-024 Requests arriving while busy SHALL be held in pending and served in round-robin order; no request lost.
REQ-025 Requests before init_done_out=1 SHALL be held pending, not dropped.
REQ-026 A winner with offset >= MICROCODE_SIZE SHALL still be granted and started unchanged (executor tolerates).
REQ-027 NUM_REQ=1 SHALL degenerate to always granting index 0.

Reset
REQ-028 On reset_in=1 SHALL immediately: state=S_BOOT, pending=0, last_grant=NUM_REQ-1, owner=boot, procedure_offset_out=0, procedure_start_out=0, grant_out=0, done_out=0, init_done_out=0, busy_out=1.
REQ-029 Reset mid-procedure SHALL abandon the owner with no done_out pulse and rerun init after release.
REQ-030 init_done_out SHALL clear only on reset.

Verification
REQ-031 Reset release, done_in=1, executor drops done_in 2 cycles after start, raises 10 cycles later -> start with offset INIT_OFFSET, init_done_out=1 after done_in rises, no grant/done pulses.
REQ-032 After init, req_in=4'b0101 for 1 cycle, offsets 5/9/13/17 -> grant[0] offset 5, done[0], then grant[2] offset 13, done[2], pending 0.
REQ-033 All four req_in held high continuously -> grants in order 0,1,2,3,0,... each 1-cycle pulse.
REQ-034 req_in[1] pulsed during S_BOOT -> served immediately after init_done_out rises with offset 9.
REQ-035 req_in[3] re-pulsed on its grant cycle -> requester 3 granted a second time after current round.
REQ-036 reset_in asserted during S_BUSY -> all outputs to reset values same cycle, no done_out, boot init reissued after release.
